// File: rtl/skinny_sbox8_domd_pipelined.sv
// Order-D DOM-masked SKINNY-128 8-bit S-box, one round per pipeline stage.
// Stage k registers round k's input shares and its two DOM-indep AND product matrices.
module skinny_sbox8_domd_pipelined #(
  parameter int D  = 1,
  parameter int RW = 4*D*(D+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*(D+1)-1:0] si,
  input  logic [RW-1:0]      r,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*(D+1)-1:0] so
);

  localparam int NS     = D + 1;
  localparam int XW     = 8 * NS;
  localparam int PW     = NS * NS;
  localparam int NZ     = D * (D + 1) / 2;
  localparam int RK     = 2 * NZ;
  localparam int STAGES = 4;

  typedef logic [XW-1:0] shares_t;
  typedef logic [PW-1:0] prod_t;
  typedef logic [NS-1:0] bits_t;
  typedef logic [NZ-1:0] rnd_t;

  function automatic bits_t share_bit(input shares_t x, input int k);
    bits_t b;
    for (int s = 0; s < NS; s++) b[s] = x[8*s+k];
    return b;
  endfunction

  // Product matrix entry [m][n] = a_m & b_n, off-diagonal pairs share one random bit.
  function automatic prod_t dom_products(input bits_t a, input bits_t b, input rnd_t z);
    prod_t p;
    for (int m = 0; m < NS; m++)
      for (int n = 0; n < NS; n++)
        p[m*NS+n] = a[m] & b[n];
    for (int i = 0; i < NS; i++)
      for (int j = i + 1; j < NS; j++) begin
        p[i*NS+j] = p[i*NS+j] ^ z[i*NS - (i*(i+1))/2 + (j-i-1)];
        p[j*NS+i] = p[j*NS+i] ^ z[i*NS - (i*(i+1))/2 + (j-i-1)];
      end
    return p;
  endfunction

  function automatic bits_t dom_compress(input prod_t p);
    bits_t c;
    c = '0;
    for (int m = 0; m < NS; m++)
      for (int n = 0; n < NS; n++)
        c[m] = c[m] ^ p[m*NS+n];
    return c;
  endfunction

  function automatic shares_t mix_apply(input shares_t x, input prod_t pa, input prod_t pb);
    shares_t y;
    bits_t   ca;
    bits_t   cb;
    y  = x;
    ca = dom_compress(pa);
    cb = dom_compress(pb);
    for (int s = 0; s < NS; s++) begin
      y[8*s]   = x[8*s]   ^ ca[s];
      y[8*s+4] = x[8*s+4] ^ cb[s];
    end
    return y;
  endfunction

  function automatic shares_t permute_all(input shares_t x);
    shares_t    y;
    logic [7:0] b;
    y = '0;
    for (int s = 0; s < NS; s++) begin
      b = x[8*s +: 8];
      y[8*s +: 8] = {b[2], b[1], b[7], b[6], b[4], b[0], b[3], b[5]};
    end
    return y;
  endfunction

  function automatic shares_t swap_all(input shares_t x);
    shares_t    y;
    logic [7:0] b;
    y = '0;
    for (int s = 0; s < NS; s++) begin
      b = x[8*s +: 8];
      y[8*s +: 8] = {b[7:3], b[1], b[2], b[0]};
    end
    return y;
  endfunction

  // NOR(a,b) = AND(~a,~b); the inversion touches share 0 only.
  function automatic bits_t nor_in(input bits_t a);
    return a ^ bits_t'(1);
  endfunction

  logic [STAGES-1:0] vld_q, vld_d;
  shares_t           x_q  [STAGES];
  shares_t           x_d  [STAGES];
  prod_t             pa_q [STAGES];
  prod_t             pa_d [STAGES];
  prod_t             pb_q [STAGES];
  prod_t             pb_d [STAGES];
  shares_t           x_in [STAGES];
  logic              en;

  // Round-k input: raw shares for stage 0, otherwise previous round compressed and permuted.
  always_comb begin
    x_in[0] = si;
    for (int k = 1; k < STAGES; k++)
      x_in[k] = permute_all(mix_apply(x_q[k-1], pa_q[k-1], pb_q[k-1]));
  end

  // Lower randomness half feeds the bit-0 update (x3,x2), upper half the bit-4 update (x7,x6).
  always_comb begin
    en    = out_ready | ~vld_q[STAGES-1];
    vld_d = vld_q;
    for (int k = 0; k < STAGES; k++) begin
      x_d[k]  = x_q[k];
      pa_d[k] = pa_q[k];
      pb_d[k] = pb_q[k];
    end
    if (en) begin
      vld_d = {vld_q[STAGES-2:0], in_valid};
      for (int k = 0; k < STAGES; k++) begin
        x_d[k]  = x_in[k];
        pa_d[k] = dom_products(nor_in(share_bit(x_in[k], 3)), nor_in(share_bit(x_in[k], 2)),
                               r[k*RK +: NZ]);
        pb_d[k] = dom_products(nor_in(share_bit(x_in[k], 7)), nor_in(share_bit(x_in[k], 6)),
                               r[k*RK+NZ +: NZ]);
      end
    end
  end

  // Stage registers p0..p3: shares and gadget products all advance together on en.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        x_q[k]  <= '0;
        pa_q[k] <= '0;
        pb_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < STAGES; k++) begin
        x_q[k]  <= x_d[k];
        pa_q[k] <= pa_d[k];
        pb_q[k] <= pb_d[k];
      end
    end
  end

  assign in_ready  = en;
  assign out_valid = vld_q[STAGES-1];
  assign so        = swap_all(mix_apply(x_q[STAGES-1], pa_q[STAGES-1], pb_q[STAGES-1]));

endmodule

// File: tb/tb_skinny_sbox8_domd_pipelined.sv
// Bench for the masked pipelined SKINNY S-box: D=1,2,3 instances run in lockstep
// against an unmasked byte-level reference and a latency/ordering scoreboard.
module tb_skinny_sbox8_domd_pipelined;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready;
  logic        in_ready1, in_ready2, in_ready3;
  logic        out_valid1, out_valid2, out_valid3;
  logic [15:0] si1, so1;
  logic [23:0] si2, so2;
  logic [31:0] si3, so3;
  logic [7:0]  r1;
  logic [23:0] r2;
  logic [47:0] r3;

  skinny_sbox8_domd_pipelined #(.D(1)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid),
    .in_ready(in_ready1), .si(si1), .r(r1), .out_valid(out_valid1), .out_ready(out_ready), .so(so1));
  skinny_sbox8_domd_pipelined #(.D(2)) u2 (.clk(clk), .rst(rst), .in_valid(in_valid),
    .in_ready(in_ready2), .si(si2), .r(r2), .out_valid(out_valid2), .out_ready(out_ready), .so(so2));
  skinny_sbox8_domd_pipelined #(.D(3)) u3 (.clk(clk), .rst(rst), .in_valid(in_valid),
    .in_ready(in_ready3), .si(si3), .r(r3), .out_valid(out_valid3), .out_ready(out_ready), .so(so3));

  typedef struct { logic [7:0] din; logic [7:0] dout; } vec_t;

  int         tests = 0, fails = 0;
  int         cyc = 0, stall_cnt = 0, n_out = 0, last_out_cyc = 0, last_acc_cyc = 0;
  bit         zero_r = 1'b0, accepted = 1'b0, hold_prev = 1'b0;
  logic [7:0] cur_exp;
  logic [7:0] exp_q[$];
  int         acc_q[$];
  int         stl_q[$];
  logic [15:0] prev_so1;
  logic [23:0] prev_so2;
  logic [31:0] prev_so3;
  bit         ov_hist [0:4095];

  // Unmasked S8: four rounds of two NOR-XORs, bit permutation, final bit1/bit2 swap.
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    for (int rnd = 0; rnd < 4; rnd++) begin
      x[4] = x[4] ^ ~(x[7] | x[6]);
      x[0] = x[0] ^ ~(x[3] | x[2]);
      if (rnd < 3) x = {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
      else         x = {x[7:3], x[1], x[2], x[0]};
    end
    return x;
  endfunction

  function automatic logic [7:0] fold(input logic [31:0] v, input int ns);
    logic [7:0] a;
    a = 8'h00;
    for (int s = 0; s < ns; s++) a = a ^ v[8*s +: 8];
    return a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_in(input logic v, input logic [7:0] p, input logic [7:0] e);
    logic [31:0] m;
    in_valid = v;
    cur_exp  = e;
    m = $urandom; si1 = {m[7:0], p ^ m[7:0]};
    m = $urandom; si2 = {m[15:0], p ^ m[7:0] ^ m[15:8]};
    m = $urandom; si3 = {m[23:0], p ^ m[7:0] ^ m[15:8] ^ m[23:16]};
  endtask

  // One clock: check outputs against the scoreboard at negedge, then advance.
  task automatic step();
    bit exp_ov;
    int lat;
    @(negedge clk);
    exp_ov = 1'b0;
    if (exp_q.size() > 0) begin
      lat    = cyc - acc_q[0] - (stall_cnt - stl_q[0]);
      exp_ov = (lat >= 4);
    end
    check("out_valid_d1", out_valid1, exp_ov);
    check("out_valid_d2", out_valid2, exp_ov);
    check("out_valid_d3", out_valid3, exp_ov);
    check("in_ready_d1", in_ready1, !(exp_ov && !out_ready));
    check("in_ready_d3", in_ready3, !(exp_ov && !out_ready));
    if (hold_prev) begin
      check("hold_so_d1", so1, prev_so1);
      check("hold_so_d2", so2, prev_so2);
      check("hold_so_d3", so3, prev_so3);
    end
    if (exp_ov) begin
      check("data_d1", fold(so1, 2), exp_q[0]);
      check("data_d2", fold(so2, 3), exp_q[0]);
      check("data_d3", fold(so3, 4), exp_q[0]);
      if (out_ready) begin
        void'(exp_q.pop_front()); void'(acc_q.pop_front()); void'(stl_q.pop_front());
        n_out++;
        last_out_cyc = cyc;
      end
    end
    hold_prev = exp_ov && !out_ready;
    prev_so1 = so1; prev_so2 = so2; prev_so3 = so3;
    accepted = in_valid && !(exp_ov && !out_ready) && !rst;
    if (accepted) begin
      exp_q.push_back(cur_exp); acc_q.push_back(cyc); stl_q.push_back(stall_cnt);
      last_acc_cyc = cyc;
    end
    if (exp_ov && !out_ready) stall_cnt++;
    if (cyc < 4096) ov_hist[cyc] = out_valid1;
    if (rst) begin
      exp_q.delete(); acc_q.delete(); stl_q.delete();
      hold_prev = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (zero_r) begin r1 = '0; r2 = '0; r3 = '0; end
    else begin r1 = 8'($urandom); r2 = 24'($urandom); r3 = {16'($urandom), $urandom}; end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int t = 0; t < 40 && exp_q.size() > 0; t++) step();
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic sweep(input bit zr);
    int first;
    zero_r = zr;
    n_out  = 0;
    first  = 0;
    for (int i = 0; i < 256; i++) begin
      set_in(1'b1, 8'(i), sbox_ref(8'(i)));
      step();
      check("sweep_accept", accepted, 1'b1);
      if (i == 0) first = last_acc_cyc;
    end
    drain();
    check("sweep_count", n_out, 256);
    check("sweep_first_lat_lo", ov_hist[first+3], 1'b0);
    check("sweep_first_lat", ov_hist[first+4], 1'b1);
    check("sweep_span", last_out_cyc - first, 259);
    zero_r = 1'b0;
  endtask

  initial begin
    vec_t vecs[16];
    logic [7:0] lut_head[16];
    bit   bv[5];
    logic [7:0] bb[5];
    logic [7:0] be[5];
    int   fa, idx, st0;

    lut_head = '{8'h65, 8'h4c, 8'h6a, 8'h42, 8'h4b, 8'h63, 8'h43, 8'h6b,
                 8'h55, 8'h75, 8'h5a, 8'h7a, 8'h53, 8'h73, 8'h5b, 8'h7b};
    for (int i = 0; i < 16; i++) begin
      vecs[i].din  = 8'(i);
      vecs[i].dout = lut_head[i];
    end
    vecs[15].din  = 8'hff;
    vecs[15].dout = 8'hff;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    si1 = '0; si2 = '0; si3 = '0; r1 = '0; r2 = '0; r3 = '0; cur_exp = '0;
    step(); step();
    rst = 1'b0;
    check("rst_out_valid", out_valid1, 1'b0);
    check("rst_in_ready", in_ready1, 1'b1);
    check("rst_so_d1", so1, 0);
    check("rst_so_d2", so2, 0);
    check("rst_so_d3", so3, 0);

    // Known S8 values, back to back.
    for (int i = 0; i < 16; i++) begin
      set_in(1'b1, vecs[i].din, vecs[i].dout);
      step();
    end
    drain();

    sweep(1'b0);
    sweep(1'b1);

    // Backpressure: out_ready low for cycles 6..9 after the first accept.
    n_out = 0; idx = 0; fa = -1; st0 = stall_cnt;
    for (int t = 0; t < 60 && (idx < 16 || exp_q.size() > 0); t++) begin
      if (idx < 16) set_in(1'b1, 8'(idx), sbox_ref(8'(idx)));
      else in_valid = 1'b0;
      out_ready = !(fa >= 0 && (cyc - fa) >= 6 && (cyc - fa) <= 9);
      step();
      if (accepted) begin
        if (fa < 0) fa = last_acc_cyc;
        idx++;
      end
    end
    out_ready = 1'b1;
    check("bp_count", n_out, 16);
    check("bp_stall_cycles", stall_cnt - st0, 4);

    // Bubbles.
    bv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    bb = '{8'h3a, 8'h00, 8'h00, 8'hff, 8'h00};
    be = '{sbox_ref(8'h3a), 8'h00, 8'h65, 8'hff, 8'h00};
    fa = 0;
    for (int k = 0; k < 5; k++) begin
      set_in(bv[k], bb[k], be[k]);
      step();
      if (k == 0) fa = last_acc_cyc;
    end
    drain();
    for (int k = 0; k < 5; k++) check("bubble_pattern", ov_hist[fa+4+k], bv[k]);

    // Reset mid-flight.
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 8'(8'h11 * (k + 1)), sbox_ref(8'(8'h11 * (k + 1))));
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_out_valid", out_valid1, 1'b0);
    check("midrst_in_ready", in_ready1, 1'b1);
    check("midrst_so_d1", so1, 0);
    check("midrst_so_d3", so3, 0);
    set_in(1'b1, 8'h5c, sbox_ref(8'h5c));
    step();
    fa = last_acc_cyc;
    drain();
    for (int k = 1; k < 4; k++) check("midrst_no_ghost", ov_hist[fa+k], 1'b0);
    check("midrst_new_lat", ov_hist[fa+4], 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
